bounded_ud_counter: RTL and testbench
=====================================

# bounded_ud_counter

Parametrised up/down counter with programmable lower/upper bounds, programmable step, wrap or saturate mode, and boundary-event flags. It generalises the fixed-width ±1 counter used in the calculator datapath. It serves operand entry, digit scrolling and loop/iteration counts where the range is set at runtime rather than by register width. All state is in one clock domain.

## Interface
- `WIDTH`, default 8: count, data and bound width.
- `STEP_W`, default 4: step input width; must satisfy `STEP_W <= WIDTH`.

- `CLK`, in, 1: clock. All state updates on the rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `CLR`, in, 1: synchronous clear. Loads `LO` into Q and clears the sticky flags.
- `LD`, in, 1: synchronous load of `D`.
- `D`, in, WIDTH: load value.
- `CE`, in, 1: count enable. Gates counting only; it does not gate `CLR` or `LD`.
- `UD`, in, 1: direction; 1 = up, 0 = down.
- `STEP`, in, STEP_W: increment magnitude, unsigned.
- `LO`, in, WIDTH: lower bound, unsigned.
- `HI`, in, WIDTH: upper bound, unsigned.
- `MODE`, in, 1: boundary behaviour; 0 = wrap, 1 = saturate.
- `Q`, out, WIDTH: count value, registered.
- `TC`, out, 1: terminal-count pulse, registered.
- `OVF`, out, 1: sticky flag, set on an up boundary event.
- `UNF`, out, 1: sticky flag, set on a down boundary event.
- `AT_LO`, out, 1: combinational, `Q == LO`.
- `AT_HI`, out, 1: combinational, `Q == HI`.
- `BAD_BOUNDS`, out, 1: combinational, `LO > HI`.

## Operation
- **Reset values:** Q=0, TC=0, OVF=0, UNF=0. Reset may assert at any time, including mid-count, and takes effect immediately.
- **Priority at each edge:** RST > CLR > LD > count.
  - CLR: Q←LO, OVF←0, UNF←0, TC←0.
  - LD: Q←D, loaded unclamped even if outside [LO,HI]. Flags are held and TC←0.
  - Count: occurs only when CE=1, BAD_BOUNDS=0 and STEP≠0. Otherwise Q holds and TC←0.
- **Arithmetic:** all comparisons are unsigned and done at WIDTH+1 bits. Neither sum nor difference ever wraps at 2^WIDTH.
- **Up count (UD=1):**
  - If Q+STEP ≤ HI, then Q←Q+STEP and TC←0.
  - Otherwise an up boundary event occurs: Q←LO if MODE=0, Q←HI if MODE=1; TC←1 and OVF←1.
- **Down count (UD=0):**
  - If Q ≥ LO+STEP, then Q←Q−STEP and TC←0.
  - Otherwise a down boundary event occurs: Q←HI if MODE=0, Q←LO if MODE=1; TC←1 and UNF←1.
- **Wrap mode** jumps to the opposite bound. The remainder is not carried.
- **Saturate mode** at a bound keeps producing an event, with TC=1, on every enabled counting cycle.
- **Out-of-range Q** (after LD, or after bounds change):
  - Up with Q>HI is an up event.
  - Down with Q<LO is a down event.
  - Q in range behaves normally.
- **LO==HI:** Q is pinned to that value once any event occurs. Every enabled count with STEP≠0 produces TC.
- **BAD_BOUNDS=1:** counting is suppressed (Q held, TC←0, flags held). CLR and LD still act.
- **Flag lifetime:** OVF and UNF are cleared only by RST or CLR. Both may be set at the same time.
- **Input sampling:** `LO`, `HI`, `STEP`, `MODE` and `UD` may change on any cycle; the values present at the edge are used.

## Timing
- Q, TC, OVF and UNF change only on the rising CLK edge, or asynchronously on RST.
- Latency is one cycle: inputs sampled at edge N are reflected on Q, TC and flags after edge N.
- TC is high for exactly the one cycle following each edge that had a boundary event, aligned with the new Q.
- AT_LO, AT_HI and BAD_BOUNDS are combinational from Q, LO and HI. They have no registered latency.
- RST deassertion is synchronous-safe: the first edge with RST=0 performs normal priority evaluation.

## Test plan
- **Reset mid-count:** WIDTH=8; count up to Q=37, assert RST between edges → Q=0, TC=0, OVF=0, UNF=0 immediately. Q holds 0 while RST is high.
- **Wrap up:** LO=10, HI=20, STEP=3, MODE=0, UD=1, CLR then CE=1 → Q: 10, 13, 16, 19, 10. TC=1 only with the second 10. OVF=1 after that edge.
- **Saturate down:** LO=5, HI=50, STEP=4, MODE=1, LD D=12, then UD=0 CE=1 → Q: 12, 8, 5, 5. TC=1 on both 5 cycles. UNF=1, OVF=0.
- **No 2^WIDTH overflow:** WIDTH=8, LO=0, HI=255, STEP=15, Q loaded to 250, up, MODE=0 → event, Q=0, TC=1. Q must not become 9.
- **Priority:** CLR=1, LD=1, CE=1 on the same edge with LO=7 → Q=7, flags cleared. Next, LD=1 with CE=0 and D=99 → Q=99.
- **Bad bounds / out of range:** LO=30, HI=20, CE=1 → Q holds, TC=0, BAD_BOUNDS=1. Then set LO=0 with Q=99 held, HI=20, up, MODE=1 → Q=20, TC=1.

Source files
------------

// File: rtl/bounded_ud_counter.sv
// bounded_ud_counter
// Up/down counter whose range [LO, HI], step size and boundary behaviour
// (wrap or saturate) are supplied at runtime. Boundary events produce a
// one-cycle TC pulse and set the sticky OVF/UNF flags.
// STEP_W must not exceed WIDTH.

module bounded_ud_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              LD,
    input  logic [WIDTH-1:0]  D,
    input  logic              CE,
    input  logic              UD,
    input  logic [STEP_W-1:0] STEP,
    input  logic [WIDTH-1:0]  LO,
    input  logic [WIDTH-1:0]  HI,
    input  logic              MODE,
    output logic [WIDTH-1:0]  Q,
    output logic              TC,
    output logic              OVF,
    output logic              UNF,
    output logic              AT_LO,
    output logic              AT_HI,
    output logic              BAD_BOUNDS
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    // Boundary tests are done one bit wider than the count so that
    // Q+STEP and LO+STEP can never alias back into range.
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   lo_plus_step;
    logic             up_fits;
    logic             dn_fits;

    // The plain WIDTH-bit results are only used when the wide test says
    // they stay in range, so their truncation is harmless.
    logic [WIDTH-1:0] q_up;
    logic [WIDTH-1:0] q_dn;

    logic             bad_bounds;
    logic             count_en;

    assign step_x       = (WIDTH+1)'(STEP);
    assign up_sum       = {1'b0, q_q} + step_x;
    assign lo_plus_step = {1'b0, LO} + step_x;
    assign up_fits      = (up_sum <= {1'b0, HI});
    assign dn_fits      = ({1'b0, q_q} >= lo_plus_step);

    assign q_up         = q_q + WIDTH'(STEP);
    assign q_dn         = q_q - WIDTH'(STEP);

    assign bad_bounds   = (LO > HI);
    assign count_en     = CE && !bad_bounds && (STEP != '0);

    // Next-state: CLR beats LD beats counting; TC defaults low so it only
    // pulses on the cycle after a boundary event.
    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (CLR) begin
            q_d   = LO;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (LD) begin
            q_d = D;
        end else if (count_en) begin
            if (UD) begin
                if (up_fits) begin
                    q_d = q_up;
                end else begin
                    q_d   = MODE ? HI : LO;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end else begin
                if (dn_fits) begin
                    q_d = q_dn;
                end else begin
                    q_d   = MODE ? LO : HI;
                    tc_d  = 1'b1;
                    unf_d = 1'b1;
                end
            end
        end
    end

    // State register with asynchronous reset to zero count and clear flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign Q          = q_q;
    assign TC         = tc_q;
    assign OVF        = ovf_q;
    assign UNF        = unf_q;
    assign AT_LO      = (q_q == LO);
    assign AT_HI      = (q_q == HI);
    assign BAD_BOUNDS = bad_bounds;

endmodule

// File: tb/tb_bounded_ud_counter.sv
// tb_bounded_ud_counter
// Directed scenarios plus randomized traffic, all compared against an
// integer reference model of the counter's rules.

module tb_bounded_ud_counter;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          CLK;
    logic          RST;
    logic          CLR;
    logic          LD;
    logic [W-1:0]  D;
    logic          CE;
    logic          UD;
    logic [SW-1:0] STEP;
    logic [W-1:0]  LO;
    logic [W-1:0]  HI;
    logic          MODE;
    logic [W-1:0]  Q;
    logic          TC;
    logic          OVF;
    logic          UNF;
    logic          AT_LO;
    logic          AT_HI;
    logic          BAD_BOUNDS;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q   = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_unf = 0;

    bounded_ud_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLR        (CLR),
        .LD         (LD),
        .D          (D),
        .CE         (CE),
        .UD         (UD),
        .STEP       (STEP),
        .LO         (LO),
        .HI         (HI),
        .MODE       (MODE),
        .Q          (Q),
        .TC         (TC),
        .OVF        (OVF),
        .UNF        (UNF),
        .AT_LO      (AT_LO),
        .AT_HI      (AT_HI),
        .BAD_BOUNDS (BAD_BOUNDS)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Apply the counter rules with ordinary integer arithmetic to the
    // inputs that will be present at the coming edge.
    function automatic void model_edge();
        int lo, hi, s, q;
        lo = int'(LO);
        hi = int'(HI);
        s  = int'(STEP);
        q  = m_q;
        if (RST) begin
            m_q = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else if (CLR) begin
            m_q = lo; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else if (LD) begin
            m_q = int'(D); m_tc = 0;
        end else if (CE && lo <= hi && s != 0) begin
            if (UD) begin
                if (q + s <= hi) begin
                    m_q = q + s; m_tc = 0;
                end else begin
                    m_q = MODE ? hi : lo; m_tc = 1; m_ovf = 1;
                end
            end else begin
                if (q >= lo + s) begin
                    m_q = q - s; m_tc = 0;
                end else begin
                    m_q = MODE ? lo : hi; m_tc = 1; m_unf = 1;
                end
            end
        end else begin
            m_tc = 0;
        end
    endfunction

    task automatic step_clock();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CLR = 0; LD = 0; CE = 0; UD = 0; D = '0;
        STEP = '0; LO = '0; HI = '0; MODE = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        idle_inputs();
        #2;
        checks++;
        if (Q !== 8'd0 || TC !== 1'b0 || OVF !== 1'b0 || UNF !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: Q=%0d TC=%b OVF=%b UNF=%b expected 0 0 0 0", Q, TC, OVF, UNF);
        end
        CLR = 1; LD = 1; D = 8'd55; CE = 1;
        step_clock();
        step_clock();
        checks++;
        if (Q !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: Q=%0d expected 0", Q);
        end
        idle_inputs();
        RST = 0;
    endtask

    task automatic test_wrap_up();
        int exp_q[5]  = '{10, 13, 16, 19, 10};
        int exp_tc[5] = '{0, 0, 0, 0, 1};
        LO = 8'd10; HI = 8'd20; STEP = 4'd3; MODE = 0; UD = 1;
        CLR = 1;
        step_clock();
        CLR = 0; CE = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Q !== 8'(exp_q[i]) || TC !== 1'(exp_tc[i])) begin
                errors++;
                $display("[TB] FAIL wrap_up[%0d]: Q=%0d TC=%b expected %0d %0d", i, Q, TC, exp_q[i], exp_tc[i]);
            end
            if (i < 4) step_clock();
        end
        checks++;
        if (OVF !== 1'b1 || UNF !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_up_flags: OVF=%b UNF=%b expected 1 0", OVF, UNF);
        end
        CE = 0;
    endtask

    task automatic test_saturate_down();
        int exp_q[4]  = '{12, 8, 5, 5};
        int exp_tc[4] = '{0, 0, 1, 1};
        LO = 8'd5; HI = 8'd50; STEP = 4'd4; MODE = 1; UD = 0;
        CLR = 1;
        step_clock();
        CLR = 0; LD = 1; D = 8'd12;
        step_clock();
        LD = 0; CE = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (Q !== 8'(exp_q[i]) || TC !== 1'(exp_tc[i])) begin
                errors++;
                $display("[TB] FAIL sat_down[%0d]: Q=%0d TC=%b expected %0d %0d", i, Q, TC, exp_q[i], exp_tc[i]);
            end
            if (i < 3) step_clock();
        end
        checks++;
        if (UNF !== 1'b1 || OVF !== 1'b0 || AT_LO !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_down_flags: UNF=%b OVF=%b AT_LO=%b expected 1 0 1", UNF, OVF, AT_LO);
        end
        CE = 0;
    endtask

    task automatic test_no_overflow();
        LO = 8'd0; HI = 8'd255; STEP = 4'd15; MODE = 0; UD = 1;
        LD = 1; D = 8'd250;
        step_clock();
        LD = 0; CE = 1;
        step_clock();
        CE = 0;
        checks++;
        if (Q !== 8'd0 || TC !== 1'b1 || OVF !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_overflow: Q=%0d TC=%b OVF=%b expected 0 1 1", Q, TC, OVF);
        end
    endtask

    task automatic test_priority();
        LO = 8'd7; HI = 8'd100; STEP = 4'd2; UD = 1; MODE = 0;
        CLR = 1; LD = 1; CE = 1; D = 8'd44;
        step_clock();
        checks++;
        if (Q !== 8'd7 || OVF !== 1'b0 || UNF !== 1'b0 || TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_clr: Q=%0d OVF=%b UNF=%b TC=%b expected 7 0 0 0", Q, OVF, UNF, TC);
        end
        CLR = 0; LD = 1; CE = 0; D = 8'd99;
        step_clock();
        LD = 0;
        checks++;
        if (Q !== 8'd99) begin
            errors++;
            $display("[TB] FAIL prio_ld: Q=%0d expected 99", Q);
        end
    endtask

    task automatic test_bad_bounds();
        LO = 8'd30; HI = 8'd20; CE = 1; UD = 1; STEP = 4'd1; MODE = 0;
        step_clock();
        checks++;
        if (Q !== 8'd99 || TC !== 1'b0 || BAD_BOUNDS !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_bounds: Q=%0d TC=%b BAD=%b expected 99 0 1", Q, TC, BAD_BOUNDS);
        end
        LO = 8'd0; HI = 8'd20; MODE = 1;
        step_clock();
        CE = 0;
        checks++;
        if (Q !== 8'd20 || TC !== 1'b1 || AT_HI !== 1'b1 || BAD_BOUNDS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL out_of_range: Q=%0d TC=%b AT_HI=%b BAD=%b expected 20 1 1 0", Q, TC, AT_HI, BAD_BOUNDS);
        end
    endtask

    task automatic test_reset_mid_count();
        LO = 8'd0; HI = 8'd255; STEP = 4'd7; UD = 1; MODE = 0;
        LD = 1; D = 8'd30;
        step_clock();
        LD = 0; CE = 1;
        step_clock();
        checks++;
        if (Q !== 8'd37) begin
            errors++;
            $display("[TB] FAIL mid_count_pre: Q=%0d expected 37", Q);
        end
        #3;
        RST = 1;
        m_q = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        #1;
        checks++;
        if (Q !== 8'd0 || TC !== 1'b0 || OVF !== 1'b0 || UNF !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_count_reset: Q=%0d TC=%b OVF=%b UNF=%b expected 0 0 0 0", Q, TC, OVF, UNF);
        end
        step_clock();
        checks++;
        if (Q !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_count_hold: Q=%0d expected 0", Q);
        end
        RST = 0;
        step_clock();
        checks++;
        if (Q !== 8'd7) begin
            errors++;
            $display("[TB] FAIL post_reset_count: Q=%0d expected 7", Q);
        end
        CE = 0;
    endtask

    task automatic test_random();
        int lo, hi, t;
        lo = 10; hi = 60;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                lo = $urandom_range(0, 200);
                hi = lo + $urandom_range(0, 55);
                if ($urandom_range(0, 3) == 0) hi = 255;
                if ($urandom_range(0, 5) == 0) hi = lo;
                if ($urandom_range(0, 7) == 0) begin
                    t = lo; lo = hi + 1; hi = t;
                    if (lo > 255) lo = 0;
                end
            end
            LO   = 8'(lo);
            HI   = 8'(hi);
            CLR  = ($urandom_range(0, 29) == 0);
            LD   = ($urandom_range(0, 11) == 0);
            D    = 8'($urandom_range(0, 255));
            CE   = ($urandom_range(0, 4) != 0);
            UD   = 1'($urandom_range(0, 1));
            STEP = 4'($urandom_range(0, 15));
            MODE = 1'($urandom_range(0, 1));
            step_clock();
            checks++;
            if (Q !== 8'(m_q) || TC !== 1'(m_tc) || OVF !== 1'(m_ovf) || UNF !== 1'(m_unf)) begin
                errors++;
                $display("[TB] FAIL random[%0d] regs: Q=%0d TC=%b OVF=%b UNF=%b expected %0d %0d %0d %0d",
                         n, Q, TC, OVF, UNF, m_q, m_tc, m_ovf, m_unf);
            end
            checks++;
            if (AT_LO !== (m_q == lo) || AT_HI !== (m_q == hi) || BAD_BOUNDS !== (lo > hi)) begin
                errors++;
                $display("[TB] FAIL random[%0d] comb: AT_LO=%b AT_HI=%b BAD=%b expected %0d %0d %0d",
                         n, AT_LO, AT_HI, BAD_BOUNDS, m_q == lo, m_q == hi, lo > hi);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_no_overflow();
        test_priority();
        test_bad_bounds();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
